// File: rtl/pattern_sequencer.sv
// pattern_sequencer
// Frame-level controller placed directly upstream of the pattern generator.
// It holds a program of up to DEPTH entries. Each entry gives a mode, a
// constant value, ramp deltas and a repeat count. The block plays the entries
// in order, drives the generator configuration together with the
// f_sync/sync strobes, and either stops after the last entry or loops.
// A stop request always lets the current frame finish.
//
// Ports
//   clk, rst            master clock; synchronous active-high reset
//   cfg_we/addr/data    program-entry write port, usable in any state
//                       data: [22:20] Mode, [19:8] constVal, [7:6] X,
//                             [5:4] Y, [3:0] rpt (entry plays rpt+1 frames)
//   cfg_len, loop       program length (1..DEPTH) and loop enable, sampled on start
//   start, stop         start-program pulse; request a stop at the next frame end
//   f_sync, sync        first-line / line strobes to the generator
//   Mode..Y             generator configuration of the playing entry
//   busy                high whenever the sequencer is not idle
//   frame_done          one-cycle pulse in the last cycle of each frame
//   entry_idx           index of the entry currently playing
//   frame_cnt           frames completed since the last accepted start
module pattern_sequencer #(
  parameter int LINES_PER_FRAME = 24,
  parameter int LINE_LEN        = 1290,
  parameter int REG_LINE_LEN    = 4096,
  parameter int HBLANK          = 4,
  parameter int DEPTH           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [22:0] cfg_data,
  input  logic [3:0]  cfg_len,
  input  logic        loop,
  input  logic        start,
  input  logic        stop,
  output logic        f_sync,
  output logic        sync,
  output logic [2:0]  Mode,
  output logic [11:0] constVal,
  output logic [1:0]  X,
  output logic [1:0]  Y,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  entry_idx,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SYNC   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  localparam logic [2:0]  MODE_REGULAR = 3'b001;
  localparam logic [15:0] ACT_LAST     = 16'(LINE_LEN - 1);
  localparam logic [15:0] ACT_LAST_REG = 16'(REG_LINE_LEN - 1);
  localparam logic [15:0] HB_LAST      = 16'(HBLANK - 1);
  localparam logic [15:0] LINE_LAST    = 16'(LINES_PER_FRAME - 1);

  logic [22:0] prog_q [DEPTH];

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  len_q, len_d;
  logic        loop_q, loop_d;
  logic        stop_q, stop_d;
  logic [15:0] line_q, line_d;
  logic [3:0]  rep_q, rep_d;
  logic [3:0]  rpt_q, rpt_d;
  logic        end_q, end_d;
  logic [15:0] timer_q, timer_d;

  logic        f_sync_q, f_sync_d;
  logic        sync_q, sync_d;
  logic [2:0]  mode_q, mode_d;
  logic [11:0] const_q, const_d;
  logic [1:0]  x_q, x_d;
  logic [1:0]  y_q, y_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic [2:0]  entry_idx_q, entry_idx_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic        start_ok_s;
  logic        clr_cnt_s;
  logic [3:0]  idx_inc_s;
  logic [15:0] act_last_s;
  logic [22:0] entry_s;
  logic        cfg_addr_ok_s;

  assign start_ok_s    = start && (cfg_len != 4'd0) && ({28'd0, cfg_len} <= $unsigned(DEPTH));
  assign cfg_addr_ok_s = ({29'd0, cfg_addr} < $unsigned(DEPTH));
  assign idx_inc_s     = {1'b0, idx_q} + 4'd1;
  assign act_last_s    = (mode_q == MODE_REGULAR) ? ACT_LAST_REG : ACT_LAST;

  // Sequencing FSM: next state, entry pointer and line/repeat/timer counters.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    loop_d    = loop_q;
    line_d    = line_q;
    rep_d     = rep_q;
    timer_d   = timer_q;
    clr_cnt_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_d   = ST_LOAD;
          idx_d     = 3'd0;
          len_d     = cfg_len;
          loop_d    = loop;
          clr_cnt_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A Mode of 000 marks the end of the program, even when looping.
        if (end_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SYNC;
          line_d  = 16'd0;
          rep_d   = 4'd0;
          timer_d = 16'd0;
        end
      end
      ST_SYNC: begin
        state_d = ST_ACTIVE;
        timer_d = 16'd0;
      end
      ST_ACTIVE: begin
        if (timer_q == act_last_s) begin
          state_d = ST_GAP;
          timer_d = 16'd0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (timer_q != HB_LAST) begin
          timer_d = timer_q + 16'd1;
        end else begin
          timer_d = 16'd0;
          if (line_q != LINE_LAST) begin
            line_d  = line_q + 16'd1;
            state_d = ST_SYNC;
          end else if (stop_q || stop) begin
            // A stop raised during this final cycle still ends the program here.
            state_d = ST_IDLE;
          end else if (rep_q < rpt_q) begin
            rep_d   = rep_q + 4'd1;
            line_d  = 16'd0;
            state_d = ST_SYNC;
          end else if (idx_inc_s == len_q) begin
            if (loop_q) begin
              idx_d   = 3'd0;
              state_d = ST_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d   = idx_inc_s[2:0];
            state_d = ST_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs, sticky stop flag and the entry snapshot taken on LOAD.
  always_comb begin
    entry_s = prog_q[idx_d];

    if (state_d == ST_IDLE) begin
      stop_d = 1'b0;
    end else if (stop && (state_q != ST_IDLE)) begin
      stop_d = 1'b1;
    end else begin
      stop_d = stop_q;
    end

    // The entry is sampled as LOAD is entered, so a later write to the
    // playing entry only shows up at its next LOAD. End markers leave the
    // generator configuration untouched.
    if (state_d == ST_LOAD) begin
      end_d = (entry_s[22:20] == 3'b000);
      rpt_d = entry_s[3:0];
      if (entry_s[22:20] != 3'b000) begin
        mode_d  = entry_s[22:20];
        const_d = entry_s[19:8];
        x_d     = entry_s[7:6];
        y_d     = entry_s[5:4];
      end else begin
        mode_d  = mode_q;
        const_d = const_q;
        x_d     = x_q;
        y_d     = y_q;
      end
    end else begin
      end_d   = end_q;
      rpt_d   = rpt_q;
      mode_d  = mode_q;
      const_d = const_q;
      x_d     = x_q;
      y_d     = y_q;
    end

    sync_d       = (state_d == ST_SYNC);
    f_sync_d     = (state_d == ST_SYNC) && (line_d == 16'd0);
    busy_d       = (state_d != ST_IDLE);
    entry_idx_d  = idx_d;
    // The pulse lands in the last GAP cycle of the final line.
    frame_done_d = (state_d == ST_GAP) && (timer_d == HB_LAST) && (line_d == LINE_LAST);

    if (clr_cnt_s) begin
      frame_cnt_d = 16'd0;
    end else if (frame_done_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // State, program memory and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        prog_q[i] <= 23'd0;
      end
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      len_q        <= 4'd0;
      loop_q       <= 1'b0;
      stop_q       <= 1'b0;
      line_q       <= 16'd0;
      rep_q        <= 4'd0;
      rpt_q        <= 4'd0;
      end_q        <= 1'b0;
      timer_q      <= 16'd0;
      f_sync_q     <= 1'b0;
      sync_q       <= 1'b0;
      mode_q       <= 3'd0;
      const_q      <= 12'd0;
      x_q          <= 2'd0;
      y_q          <= 2'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      entry_idx_q  <= 3'd0;
      frame_cnt_q  <= 16'd0;
    end else begin
      if (cfg_we && cfg_addr_ok_s) begin
        prog_q[cfg_addr] <= cfg_data;
      end
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      loop_q       <= loop_d;
      stop_q       <= stop_d;
      line_q       <= line_d;
      rep_q        <= rep_d;
      rpt_q        <= rpt_d;
      end_q        <= end_d;
      timer_q      <= timer_d;
      f_sync_q     <= f_sync_d;
      sync_q       <= sync_d;
      mode_q       <= mode_d;
      const_q      <= const_d;
      x_q          <= x_d;
      y_q          <= y_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      entry_idx_q  <= entry_idx_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign f_sync     = f_sync_q;
  assign sync       = sync_q;
  assign Mode       = mode_q;
  assign constVal   = const_q;
  assign X          = x_q;
  assign Y          = y_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign entry_idx  = entry_idx_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with shortened frame geometry.
// Expected sync and frame_done events are queued when a program is started.
// They are popped and compared as the DUT emits the strobes.
module tb_pattern_sequencer;

  localparam int LPF   = 3;
  localparam int LL    = 5;
  localparam int RLL   = 9;
  localparam int HB    = 2;
  localparam int P     = 1 + LL + HB;   // line period, non-REGULAR
  localparam int PR    = 1 + RLL + HB;  // line period, REGULAR

  logic        clk = 1'b0;
  logic        rst, cfg_we, loop, start, stop;
  logic [2:0]  cfg_addr;
  logic [22:0] cfg_data;
  logic [3:0]  cfg_len;
  logic        f_sync, sync, busy, frame_done;
  logic [2:0]  Mode, entry_idx;
  logic [11:0] constVal;
  logic [1:0]  X, Y;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  pattern_sequencer #(
    .LINES_PER_FRAME(LPF), .LINE_LEN(LL), .REG_LINE_LEN(RLL), .HBLANK(HB), .DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len(cfg_len), .loop(loop), .start(start), .stop(stop),
    .f_sync(f_sync), .sync(sync), .Mode(Mode), .constVal(constVal), .X(X), .Y(Y),
    .busy(busy), .frame_done(frame_done), .entry_idx(entry_idx), .frame_cnt(frame_cnt)
  );

  typedef struct {
    int         cyc;
    logic       fs;
    logic [2:0] mode;
    logic [11:0] cval;
    logic [1:0] x;
    logic [1:0] y;
    logic [2:0] idx;
  } sync_ev_t;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
  } fd_ev_t;

  sync_ev_t exp_sync[$];
  fd_ev_t   exp_fd[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t0     = 0;
  logic prev_sync = 1'b0;

  function automatic logic [22:0] mk(input logic [2:0] m, input logic [11:0] c,
                                     input logic [1:0] x, input logic [1:0] y,
                                     input logic [3:0] r);
    return {m, c, x, y, r};
  endfunction

  // Per-cycle observation of the strobes against the queued expectations.
  task automatic monitor();
    sync_ev_t e;
    fd_ev_t   f;
    checks++;
    assert (!(f_sync === 1'b1 && sync !== 1'b1)) else begin
      errors++; $error("FAIL fsync_without_sync cycle=%0d f_sync=%b sync=%b expected sync=1", cyc, f_sync, sync);
    end
    if (sync === 1'b1) begin
      checks++;
      assert (prev_sync !== 1'b1) else begin
        errors++; $error("FAIL sync_width cycle=%0d observed two consecutive sync cycles expected one", cyc);
      end
      checks++;
      assert (exp_sync.size() != 0) else begin
        errors++; $error("FAIL unexpected_sync cycle=%0d observed sync=1 expected no sync", cyc);
      end
      if (exp_sync.size() != 0) begin
        e = exp_sync.pop_front();
        checks++;
        assert ({cyc, f_sync, Mode, constVal, X, Y, entry_idx} === {e.cyc, e.fs, e.mode, e.cval, e.x, e.y, e.idx}) else begin
          errors++;
          $error("FAIL sync_event observed cyc=%0d fs=%b mode=%b cval=%h x=%b y=%b idx=%0d expected cyc=%0d fs=%b mode=%b cval=%h x=%b y=%b idx=%0d",
                 cyc, f_sync, Mode, constVal, X, Y, entry_idx, e.cyc, e.fs, e.mode, e.cval, e.x, e.y, e.idx);
        end
      end
    end
    if (frame_done === 1'b1) begin
      checks++;
      assert (exp_fd.size() != 0) else begin
        errors++; $error("FAIL unexpected_frame_done cycle=%0d observed frame_done=1 expected none", cyc);
      end
      if (exp_fd.size() != 0) begin
        f = exp_fd.pop_front();
        checks++;
        assert ({cyc, frame_cnt, busy} === {f.cyc, f.cnt, 1'b1}) else begin
          errors++;
          $error("FAIL frame_done_event observed cyc=%0d cnt=%0d busy=%b expected cyc=%0d cnt=%0d busy=1",
                 cyc, frame_cnt, busy, f.cyc, f.cnt);
        end
      end
    end
    prev_sync = sync;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [22:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // The cycle in which start is high is cycle 0 of the program (t0).
  task automatic do_start(input logic [3:0] len, input logic lp);
    start = 1'b1; cfg_len = len; loop = lp; t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic push_frame(input int s, input int p, input logic [22:0] ent,
                            input logic [2:0] idx, input logic [15:0] cnt);
    for (int ln = 0; ln < LPF; ln++) begin
      exp_sync.push_back('{s + ln * p, (ln == 0), ent[22:20], ent[19:8], ent[7:6], ent[5:4], idx});
    end
    exp_fd.push_back('{s + LPF * p - 1, cnt});
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++; $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic chk_drained(input string tag);
    checks++;
    assert (exp_sync.size() == 0 && exp_fd.size() == 0) else begin
      errors++; $error("FAIL %s pending sync=%0d frame_done=%0d expected 0 and 0", tag, exp_sync.size(), exp_fd.size());
    end
  endtask

  logic [22:0] e0, e1;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 23'd0;
    cfg_len = 4'd0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    tick(); tick();
    chk("reset_outputs", {15'd0, f_sync, sync, Mode, constVal, X, Y, busy, frame_done, entry_idx},
        32'd0);
    chk("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Single CONST frame, no loop.
    e0 = mk(3'b010, 12'h5A5, 2'b00, 2'b00, 4'd0);
    wr(3'd0, e0);
    do_start(4'd1, 1'b0);
    push_frame(t0 + 2, P, e0, 3'd0, 16'd1);
    run_to(t0 + 27);
    chk("const_busy_after", {31'd0, busy}, 32'd0);
    chk("const_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("const_hold_value", {20'd0, constVal}, 32'h5A5);
    chk_drained("const_drain");

    // REGULAR entry played twice.
    e0 = mk(3'b001, 12'h123, 2'b11, 2'b01, 4'd1);
    wr(3'd0, e0);
    do_start(4'd1, 1'b0);
    push_frame(t0 + 2, PR, e0, 3'd0, 16'd1);
    push_frame(t0 + 2 + LPF * PR, PR, e0, 3'd0, 16'd2);
    run_to(t0 + 2 + 2 * LPF * PR + 2);
    chk("regular_busy_after", {31'd0, busy}, 32'd0);
    chk("regular_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    chk_drained("regular_drain");

    // Two-entry looping program, stopped during its third frame.
    e0 = mk(3'b011, 12'h0F0, 2'b00, 2'b00, 4'd0);
    e1 = mk(3'b100, 12'h321, 2'b01, 2'b10, 4'd0);
    wr(3'd0, e0);
    wr(3'd1, e1);
    do_start(4'd2, 1'b1);
    push_frame(t0 + 2, P, e0, 3'd0, 16'd1);
    push_frame(t0 + 27, P, e1, 3'd1, 16'd2);
    push_frame(t0 + 52, P, e0, 3'd0, 16'd3);
    run_to(t0 + 25);
    chk("loop_mode_before_load", {29'd0, Mode}, 32'd3);
    run_to(t0 + 26);
    chk("loop_mode_in_load", {29'd0, Mode}, 32'd4);
    chk("loop_idx_in_load", {29'd0, entry_idx}, 32'd1);
    chk("loop_no_sync_in_load", {31'd0, sync}, 32'd0);
    run_to(t0 + 40);
    start = 1'b1; cfg_len = 4'd1; loop = 1'b0;
    tick();
    start = 1'b0;
    run_to(t0 + 60);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    run_to(t0 + 80);
    chk("loop_stop_busy", {31'd0, busy}, 32'd0);
    chk("loop_stop_frame_cnt", {16'd0, frame_cnt}, 32'd3);
    chk("loop_mode_held", {29'd0, Mode}, 32'd3);
    chk_drained("loop_drain");

    // Stop mid-line 1 of frame 0 of a repeating, looping entry.
    e0 = mk(3'b010, 12'hABC, 2'b10, 2'b11, 4'd3);
    wr(3'd0, e0);
    do_start(4'd1, 1'b1);
    push_frame(t0 + 2, P, e0, 3'd0, 16'd1);
    run_to(t0 + 2 + P + 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    run_to(t0 + 50);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk_drained("stop_drain");

    // End marker in entry 1 terminates a looping program.
    e0 = mk(3'b101, 12'h777, 2'b00, 2'b01, 4'd0);
    wr(3'd0, e0);
    wr(3'd1, 23'd0);
    do_start(4'd4, 1'b1);
    push_frame(t0 + 2, P, e0, 3'd0, 16'd1);
    run_to(t0 + 26);
    chk("marker_busy_in_load", {31'd0, busy}, 32'd1);
    run_to(t0 + 27);
    chk("marker_busy_after", {31'd0, busy}, 32'd0);
    run_to(t0 + 60);
    chk("marker_mode_held", {29'd0, Mode}, 32'd5);
    chk("marker_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk_drained("marker_drain");

    // Reset during ACTIVE aborts and clears the program.
    e0 = mk(3'b110, 12'h0AA, 2'b01, 2'b01, 4'd0);
    wr(3'd0, e0);
    do_start(4'd1, 1'b0);
    exp_sync.push_back('{t0 + 2, 1'b1, 3'b110, 12'h0AA, 2'b01, 2'b01, 3'd0});
    run_to(t0 + 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_outputs", {15'd0, f_sync, sync, Mode, constVal, X, Y, busy, frame_done, entry_idx},
        32'd0);
    chk("abort_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    do_start(4'd0, 1'b0);
    chk("len0_ignored", {31'd0, busy}, 32'd0);
    do_start(4'd9, 1'b0);
    chk("len9_ignored", {31'd0, busy}, 32'd0);
    do_start(4'd1, 1'b0);
    chk("cleared_entry_load", {31'd0, busy}, 32'd1);
    tick();
    chk("cleared_entry_idle", {31'd0, busy}, 32'd0);
    run_to(cyc + 30);
    chk_drained("abort_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
